cachepool_boot_seq: RTL and testbench

Synthesizable boot sequencer for the CachePool cluster.
- After a start command, it writes the entry point into the cluster peripheral BOOT_CONTROL register over a reqrsp request/response port.
- It then pulses debug_req to wake all cores and supervises the run until eoc, with an optional timeout.
- It sits between an SoC host/control register and the cluster's reqrsp-to-AXI ingress and debug_req inputs.

---
 rtl/cachepool_boot_pkg.sv | 33 +++
 rtl/cachepool_boot_cnt.sv | 35 +++
 rtl/cachepool_boot_seq.sv | 177 +++++++++++++++++
 tb/tb_cachepool_boot_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cachepool_boot_pkg.sv
// Shared types and constants for the CachePool cluster boot sequencer.
package cachepool_boot_pkg;

    typedef enum logic [2:0] {
        BOOT_IDLE,
        BOOT_DELAY,
        BOOT_WRITE,
        BOOT_RESP,
        BOOT_WAKE,
        BOOT_RUN,
        BOOT_DONE,
        BOOT_ERROR
    } boot_state_e;

    typedef logic [31:0] boot_cnt_t;

    // Cluster memory map; BOOT_CONTROL lives inside the cluster peripheral block.
    localparam logic [47:0] PeriStartAddr = 48'h0;
    localparam logic [47:0] SPATZ_CLUSTER_PERIPHERAL_CLUSTER_BOOT_CONTROL_OFFSET = 48'h0;
    localparam logic [47:0] BootCtrlAddrDefault =
        PeriStartAddr + SPATZ_CLUSTER_PERIPHERAL_CLUSTER_BOOT_CONTROL_OFFSET;

    function automatic int unsigned boot_cnt_width(input int unsigned a,
                                                   input int unsigned b,
                                                   input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cachepool_boot_cnt.sv
// Loadable down-counter shared by the boot DELAY and WAKE phases.
module cachepool_boot_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cachepool_boot_seq.sv
// Boot sequencer: writes the entry point to BOOT_CONTROL, wakes the cores
// through debug_req and supervises the run until end-of-computation.
module cachepool_boot_seq
    import cachepool_boot_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 48,
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          NumCores     = 4,
    parameter logic [AddrWidth-1:0] BootCtrlAddr = AddrWidth'(BootCtrlAddrDefault),
    parameter int unsigned          BootDelay    = 1000,
    parameter int unsigned          WakeCycles   = 1,
    parameter int unsigned          EocTimeout   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [31:0]            entry_point_i,
    output logic [AddrWidth-1:0]   q_addr_o,
    output logic [DataWidth-1:0]   q_data_o,
    output logic                   q_write_o,
    output logic [DataWidth/8-1:0] q_strb_o,
    output logic                   q_valid_o,
    input  logic                   q_ready_i,
    input  logic                   p_valid_i,
    input  logic                   p_error_i,
    output logic                   p_ready_o,
    output logic [NumCores-1:0]    debug_req_o,
    input  logic                   eoc_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic                   err_timeout_o,
    output logic [31:0]            cycles_o
);

    localparam int unsigned CntWidth = boot_cnt_width(BootDelay, WakeCycles, EocTimeout);

    // The phase counter holds remaining cycles minus one, so zero_o marks the final cycle.
    localparam logic [CntWidth-1:0] DelayLoad = (BootDelay == 0) ? '0 : CntWidth'(BootDelay - 1);
    localparam logic [CntWidth-1:0] WakeLoad  = CntWidth'(WakeCycles - 1);
    localparam boot_cnt_t TimeoutLast = (EocTimeout == 0) ? '0 : boot_cnt_t'(EocTimeout - 1);

    boot_state_e       state_q, state_d;
    logic [31:0]       entry_q, entry_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              tmo_q, tmo_d;
    boot_cnt_t         cycles_q, cycles_d;
    logic              p_ready_q, p_ready_d;

    logic              cnt_load;
    logic              cnt_en;
    logic [CntWidth-1:0] cnt_value;
    logic              cnt_zero;

    cachepool_boot_cnt #(
        .Width (CntWidth)
    ) i_phase_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .en_i    (cnt_en),
        .zero_o  (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BOOT_IDLE;
            entry_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            tmo_q     <= 1'b0;
            cycles_q  <= '0;
            p_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            done_q    <= done_d;
            error_q   <= error_d;
            tmo_q     <= tmo_d;
            cycles_q  <= cycles_d;
            p_ready_q <= p_ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        done_d    = done_q;
        error_d   = error_q;
        tmo_d     = tmo_q;
        cycles_d  = cycles_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_value = '0;
        unique case (state_q)
            BOOT_IDLE, BOOT_DONE, BOOT_ERROR: begin
                if (start_i) begin
                    entry_d  = entry_point_i;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    tmo_d    = 1'b0;
                    cycles_d = '0;
                    if (BootDelay == 0) begin
                        state_d = BOOT_WRITE;
                    end else begin
                        state_d   = BOOT_DELAY;
                        cnt_load  = 1'b1;
                        cnt_value = DelayLoad;
                    end
                end
            end
            BOOT_DELAY: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_d = BOOT_WRITE;
            end
            BOOT_WRITE: begin
                if (q_ready_i) state_d = BOOT_RESP;
            end
            BOOT_RESP: begin
                if (p_valid_i) begin
                    if (p_error_i) begin
                        state_d = BOOT_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d   = BOOT_WAKE;
                        cnt_load  = 1'b1;
                        cnt_value = WakeLoad;
                    end
                end
            end
            BOOT_WAKE: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_d = BOOT_RUN;
            end
            BOOT_RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + boot_cnt_t'(1);
                // eoc takes priority over a timeout landing in the same cycle.
                if (eoc_i) begin
                    state_d = BOOT_DONE;
                    done_d  = 1'b1;
                end else if ((EocTimeout != 0) && (cycles_q == TimeoutLast)) begin
                    state_d = BOOT_ERROR;
                    error_d = 1'b1;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = BOOT_IDLE;
        endcase
        p_ready_d = (state_d inside {BOOT_IDLE, BOOT_RESP, BOOT_DONE, BOOT_ERROR});
    end

    always_comb begin
        q_valid_o     = 1'b0;
        q_write_o     = 1'b0;
        q_addr_o      = '0;
        q_data_o      = '0;
        q_strb_o      = '0;
        debug_req_o   = '0;
        busy_o        = (state_q inside {BOOT_DELAY, BOOT_WRITE, BOOT_RESP, BOOT_WAKE, BOOT_RUN});
        p_ready_o     = p_ready_q;
        done_o        = done_q;
        error_o       = error_q;
        err_timeout_o = tmo_q;
        cycles_o      = cycles_q;
        if (state_q == BOOT_WRITE) begin
            q_valid_o = 1'b1;
            q_write_o = 1'b1;
            q_addr_o  = BootCtrlAddr;
            q_data_o  = DataWidth'(entry_q);
            q_strb_o  = '1;
        end
        if (state_q == BOOT_WAKE) debug_req_o = '1;
    end

endmodule

// File: tb/tb_cachepool_boot_seq.sv
// Scoreboard bench for cachepool_boot_seq: two instances cover the
// delayed/no-timeout and zero-delay/long-wake/timeout configurations.
module tb_cachepool_boot_seq;

    localparam logic [47:0] ADDR = 48'h0000_4000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] entry = '0;
    logic        q_ready = 1'b1;
    logic        p_valid = 1'b0;
    logic        p_error = 1'b0;
    logic        eoc = 1'b0;
    logic        sel = 1'b0;

    logic [47:0] a_q_addr, b_q_addr, q_addr_o;
    logic [31:0] a_q_data, b_q_data, q_data_o;
    logic        a_q_write, b_q_write, q_write_o;
    logic [3:0]  a_q_strb, b_q_strb, q_strb_o;
    logic        a_q_valid, b_q_valid, q_valid_o;
    logic        a_p_ready, b_p_ready, p_ready_o;
    logic [3:0]  a_dbg, b_dbg, debug_req_o;
    logic        a_busy, b_busy, busy_o;
    logic        a_done, b_done, done_o;
    logic        a_err, b_err, error_o;
    logic        a_tmo, b_tmo, err_timeout_o;
    logic [31:0] a_cyc, b_cyc, cycles_o;

    int          n_checks = 0;
    int          n_pass = 0;
    int          hs_count = 0;
    bit          dbg_seen = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cachepool_boot_seq #(
        .AddrWidth(48), .DataWidth(32), .NumCores(4), .BootCtrlAddr(ADDR),
        .BootDelay(4), .WakeCycles(1), .EocTimeout(0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .entry_point_i(entry),
        .q_addr_o(a_q_addr), .q_data_o(a_q_data), .q_write_o(a_q_write), .q_strb_o(a_q_strb),
        .q_valid_o(a_q_valid), .q_ready_i(q_ready), .p_valid_i(p_valid), .p_error_i(p_error),
        .p_ready_o(a_p_ready), .debug_req_o(a_dbg), .eoc_i(eoc), .busy_o(a_busy),
        .done_o(a_done), .error_o(a_err), .err_timeout_o(a_tmo), .cycles_o(a_cyc)
    );

    cachepool_boot_seq #(
        .AddrWidth(48), .DataWidth(32), .NumCores(4), .BootCtrlAddr(ADDR),
        .BootDelay(0), .WakeCycles(3), .EocTimeout(20)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .entry_point_i(entry),
        .q_addr_o(b_q_addr), .q_data_o(b_q_data), .q_write_o(b_q_write), .q_strb_o(b_q_strb),
        .q_valid_o(b_q_valid), .q_ready_i(q_ready), .p_valid_i(p_valid), .p_error_i(p_error),
        .p_ready_o(b_p_ready), .debug_req_o(b_dbg), .eoc_i(eoc), .busy_o(b_busy),
        .done_o(b_done), .error_o(b_err), .err_timeout_o(b_tmo), .cycles_o(b_cyc)
    );

    assign q_addr_o      = sel ? b_q_addr  : a_q_addr;
    assign q_data_o      = sel ? b_q_data  : a_q_data;
    assign q_write_o     = sel ? b_q_write : a_q_write;
    assign q_strb_o      = sel ? b_q_strb  : a_q_strb;
    assign q_valid_o     = sel ? b_q_valid : a_q_valid;
    assign p_ready_o     = sel ? b_p_ready : a_p_ready;
    assign debug_req_o   = sel ? b_dbg     : a_dbg;
    assign busy_o        = sel ? b_busy    : a_busy;
    assign done_o        = sel ? b_done    : a_done;
    assign error_o       = sel ? b_err     : a_err;
    assign err_timeout_o = sel ? b_tmo     : a_tmo;
    assign cycles_o      = sel ? b_cyc     : a_cyc;

    function automatic logic [126:0] all_outs();
        return {q_valid_o, q_write_o, q_addr_o, q_data_o, q_strb_o, p_ready_o,
                debug_req_o, busy_o, done_o, error_o, err_timeout_o, cycles_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; entry = '0; q_ready = 1'b1;
        p_valid = 1'b0; p_error = 1'b0; eoc = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (q_valid_o !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        ok = (q_valid_o === 1'b1);
    endtask

    task automatic respond(input logic err);
        p_valid = 1'b1; p_error = err;
        step();
        p_valid = 1'b0; p_error = 1'b0;
    endtask

    task automatic start_boot(input logic [31:0] ep);
        entry = ep; start = 1'b1;
        exp_q.push_back(ep);
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b1; start = 1'b1; entry = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        n_checks++; if (all_outs() !== '0) $display("[TB] FAIL reset_outs_a: got %0h, want 0", all_outs()); else n_pass++;
        sel = 1'b1;
        n_checks++; if (all_outs() !== '0) $display("[TB] FAIL reset_outs_b: got %0h, want 0", all_outs()); else n_pass++;
        sel = 1'b0; rst = 1'b0;
        step();
        n_checks++; if ({p_ready_o, busy_o} !== 2'b10) $display("[TB] FAIL idle_drain: got %b, want 10", {p_ready_o, busy_o}); else n_pass++;
    endtask

    task automatic test_basic_boot();
        bit bad = 1'b0;
        sel = 1'b0;
        do_reset();
        start_boot(32'h8000_3000);
        for (int i = 0; i < 4; i++) begin
            if (q_valid_o !== 1'b0 || busy_o !== 1'b1) bad = 1'b1;
            step();
        end
        n_checks++; if (bad) $display("[TB] FAIL delay_quiet: got early q_valid/idle, want 4 quiet busy cycles"); else n_pass++;
        n_checks++; if (q_valid_o !== 1'b1) $display("[TB] FAIL write_at_4: got %b, want 1", q_valid_o); else n_pass++;
        n_checks++; if (q_addr_o !== ADDR) $display("[TB] FAIL write_addr: got %0h, want %0h", q_addr_o, ADDR); else n_pass++;
        n_checks++; if (q_data_o !== 32'h8000_3000) $display("[TB] FAIL write_data: got %0h, want 80003000", q_data_o); else n_pass++;
        step();
        n_checks++; if ({q_valid_o, p_ready_o} !== 2'b01) $display("[TB] FAIL resp_state: got %b, want 01", {q_valid_o, p_ready_o}); else n_pass++;
        respond(1'b0);
        n_checks++; if (debug_req_o !== 4'hF) $display("[TB] FAIL wake_on: got %0h, want f", debug_req_o); else n_pass++;
        step();
        n_checks++; if ({debug_req_o, busy_o} !== 5'b00001) $display("[TB] FAIL wake_one_cycle: got %b, want 00001", {debug_req_o, busy_o}); else n_pass++;
        repeat (49) step();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        n_checks++; if ({done_o, error_o, busy_o} !== 3'b100) $display("[TB] FAIL run_done: got %b, want 100", {done_o, error_o, busy_o}); else n_pass++;
        n_checks++; if (cycles_o !== 32'd50) $display("[TB] FAIL run_cycles: got %0d, want 50", cycles_o); else n_pass++;
        eoc = 1'b1;
        step();
        step();
        eoc = 1'b0;
        n_checks++; if ({done_o, cycles_o} !== {1'b1, 32'd50}) $display("[TB] FAIL done_sticky: got %b/%0d, want 1/50", done_o, cycles_o); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad = 1'b0;
        int hs0;
        logic [47:0] cap_addr;
        logic [31:0] cap_data;
        logic [3:0]  cap_strb;
        sel = 1'b0;
        do_reset();
        q_ready = 1'b0;
        dbg_seen = 1'b0;
        hs0 = hs_count;
        start_boot(32'hCAFE_0004);
        wait_valid(ok);
        n_checks++; if (!ok) $display("[TB] FAIL bp_valid_timeout: got no q_valid, want q_valid"); else n_pass++;
        cap_addr = q_addr_o; cap_data = q_data_o; cap_strb = q_strb_o;
        for (int i = 0; i < 7; i++) begin
            if (q_valid_o !== 1'b1 || q_addr_o !== cap_addr || q_data_o !== cap_data || q_strb_o !== cap_strb) bad = 1'b1;
            step();
        end
        n_checks++; if (bad || q_valid_o !== 1'b1) $display("[TB] FAIL bp_stable: got unstable request, want held for 7 cycles"); else n_pass++;
        q_ready = 1'b1;
        step();
        n_checks++; if (hs_count - hs0 !== 1) $display("[TB] FAIL bp_one_handshake: got %0d, want 1", hs_count - hs0); else n_pass++;
        n_checks++; if (dbg_seen !== 1'b0) $display("[TB] FAIL bp_no_early_wake: got %b, want 0", dbg_seen); else n_pass++;
        respond(1'b0);
        step();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        n_checks++; if (done_o !== 1'b1) $display("[TB] FAIL bp_done: got %b, want 1", done_o); else n_pass++;
    endtask

    task automatic test_bus_error();
        bit ok;
        sel = 1'b0;
        do_reset();
        dbg_seen = 1'b0;
        start_boot(32'h1234_5678);
        wait_valid(ok);
        n_checks++; if (!ok) $display("[TB] FAIL err_valid_timeout: got no q_valid, want q_valid"); else n_pass++;
        step();
        respond(1'b1);
        step();
        n_checks++; if ({error_o, err_timeout_o, done_o, busy_o} !== 4'b1000) $display("[TB] FAIL bus_error: got %b, want 1000", {error_o, err_timeout_o, done_o, busy_o}); else n_pass++;
        n_checks++; if ({dbg_seen, p_ready_o} !== 2'b01) $display("[TB] FAIL err_no_wake: got %b, want 01", {dbg_seen, p_ready_o}); else n_pass++;
        start_boot(32'h8000_1000);
        n_checks++; if ({error_o, busy_o} !== 2'b01) $display("[TB] FAIL err_cleared: got %b, want 01", {error_o, busy_o}); else n_pass++;
        wait_valid(ok);
        step();
        respond(1'b0);
        n_checks++; if (debug_req_o !== 4'hF) $display("[TB] FAIL err_reboot_wake: got %0h, want f", debug_req_o); else n_pass++;
        step();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        n_checks++; if ({done_o, error_o, cycles_o} !== {2'b10, 32'd1}) $display("[TB] FAIL err_reboot_done: got %b/%b/%0d, want 1/0/1", done_o, error_o, cycles_o); else n_pass++;
    endtask

    task automatic test_reset_midway();
        bit ok;
        int hs0;
        sel = 1'b0;
        do_reset();
        q_ready = 1'b0;
        start_boot(32'h0BAD_0001);
        wait_valid(ok);
        hs0 = hs_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        n_checks++; if (all_outs() !== '0) $display("[TB] FAIL rst_in_write: got %0h, want 0", all_outs()); else n_pass++;
        n_checks++; if (hs_count !== hs0) $display("[TB] FAIL rst_no_handshake: got %0d, want %0d", hs_count, hs0); else n_pass++;
        q_ready = 1'b1;
        start_boot(32'h8000_2000);
        wait_valid(ok);
        step();
        respond(1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (all_outs() !== '0) $display("[TB] FAIL rst_in_wake: got %0h, want 0", all_outs()); else n_pass++;
        start_boot(32'h8000_4000);
        wait_valid(ok);
        step();
        respond(1'b0);
        step();
        repeat (9) step();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        n_checks++; if ({done_o, cycles_o} !== {1'b1, 32'd10}) $display("[TB] FAIL rst_reboot: got %b/%0d, want 1/10", done_o, cycles_o); else n_pass++;
    endtask

    task automatic test_ignored_start();
        bit ok;
        int hs0;
        sel = 1'b0;
        do_reset();
        hs0 = hs_count;
        start_boot(32'h8000_5000);
        step();
        entry = 32'hDEAD_BEEF; start = 1'b1;
        step();
        start = 1'b0; entry = '0;
        wait_valid(ok);
        n_checks++; if (q_data_o !== 32'h8000_5000) $display("[TB] FAIL delay_start_ignored: got %0h, want 80005000", q_data_o); else n_pass++;
        step();
        respond(1'b0);
        step();
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if ({busy_o, q_valid_o, done_o} !== 3'b100) $display("[TB] FAIL run_start_ignored: got %b, want 100", {busy_o, q_valid_o, done_o}); else n_pass++;
        repeat (5) step();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        n_checks++; if ({done_o, cycles_o} !== {1'b1, 32'd10}) $display("[TB] FAIL ign_done: got %b/%0d, want 1/10", done_o, cycles_o); else n_pass++;
        n_checks++; if (hs_count - hs0 !== 1) $display("[TB] FAIL ign_one_write: got %0d, want 1", hs_count - hs0); else n_pass++;
    endtask

    task automatic test_zero_delay_wake();
        int cnt = 0;
        sel = 1'b1;
        do_reset();
        start_boot(32'h8000_6000);
        n_checks++; if ({q_valid_o, q_data_o} !== {1'b1, 32'h8000_6000}) $display("[TB] FAIL zero_delay_valid: got %b/%0h, want 1/80006000", q_valid_o, q_data_o); else n_pass++;
        step();
        respond(1'b0);
        while (debug_req_o === 4'hF && cnt < 10) begin
            cnt++;
            step();
        end
        n_checks++; if (cnt !== 3) $display("[TB] FAIL wake_len: got %0d, want 3", cnt); else n_pass++;
        n_checks++; if ({debug_req_o, busy_o} !== 5'b00001) $display("[TB] FAIL wake_to_run: got %b, want 00001", {debug_req_o, busy_o}); else n_pass++;
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        n_checks++; if ({done_o, cycles_o} !== {1'b1, 32'd1}) $display("[TB] FAIL zd_done: got %b/%0d, want 1/1", done_o, cycles_o); else n_pass++;
    endtask

    task automatic test_timeout();
        sel = 1'b1;
        do_reset();
        start_boot(32'h8000_7000);
        step();
        respond(1'b0);
        repeat (3) step();
        repeat (19) step();
        n_checks++; if ({error_o, busy_o, cycles_o} !== {2'b01, 32'd19}) $display("[TB] FAIL tmo_not_early: got %b/%b/%0d, want 0/1/19", error_o, busy_o, cycles_o); else n_pass++;
        step();
        n_checks++; if ({error_o, err_timeout_o, done_o} !== 3'b110) $display("[TB] FAIL tmo_error: got %b, want 110", {error_o, err_timeout_o, done_o}); else n_pass++;
        n_checks++; if (cycles_o !== 32'd20) $display("[TB] FAIL tmo_cycles: got %0d, want 20", cycles_o); else n_pass++;
        start_boot(32'h8000_8000);
        n_checks++; if ({error_o, err_timeout_o, cycles_o} !== {2'b00, 32'd0}) $display("[TB] FAIL tmo_cleared: got %b/%b/%0d, want 0/0/0", error_o, err_timeout_o, cycles_o); else n_pass++;
        step();
        respond(1'b0);
        repeat (3) step();
        repeat (19) step();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
        n_checks++; if ({done_o, error_o, err_timeout_o} !== 3'b100) $display("[TB] FAIL eoc_beats_tmo: got %b, want 100", {done_o, error_o, err_timeout_o}); else n_pass++;
        n_checks++; if (cycles_o !== 32'd20) $display("[TB] FAIL eoc_tmo_cycles: got %0d, want 20", cycles_o); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Scoreboard side: every accepted write must match the oldest expected entry point.
        fork
            forever begin
                logic [31:0] d;
                @(negedge clk);
                if (!rst && debug_req_o !== 4'h0) dbg_seen = 1'b1;
                if (!rst && q_valid_o === 1'b1 && q_ready === 1'b1) begin
                    hs_count++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("[TB] FAIL sb_unexpected_write: got data %0h, want no write", q_data_o);
                    end else begin
                        d = exp_q.pop_front();
                        if (q_addr_o !== ADDR || q_data_o !== d || q_strb_o !== 4'hF || q_write_o !== 1'b1)
                            $display("[TB] FAIL sb_write: got %0h/%0h/%0h/%b, want %0h/%0h/f/1",
                                     q_addr_o, q_data_o, q_strb_o, q_write_o, ADDR, d);
                        else
                            n_pass++;
                    end
                end
            end
        join_none

        test_reset();
        test_basic_boot();
        test_backpressure();
        test_bus_error();
        test_reset_midway();
        test_ignored_start();
        test_zero_delay_wake();
        test_timeout();

        n_checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL sb_drained: got %0d pending, want 0", exp_q.size()); else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
